calc_sequencer: RTL

- Front-end controller for the 4-bit signed calculator datapath.
- Turns raw switch and push-button inputs into a stepped entry sequence: operand A, operand B, operation, execute, show.
- Holds each operand register live until confirmed, waits a settle window for the combinational calculator, then captures its result.
- Sits between board I/O and the calculator / BCD display path. Also drives per-group digit enables for the display multiplexer.

---
 rtl/calc_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: button-driven operand/op entry and timed result capture for the 4-bit signed calculator
module calc_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W = 20
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       btn_enter,
   input  logic       btn_clear,
   input  logic [3:0] sw_value,
   input  logic       sw_sign,
   input  logic [1:0] sw_op,
   input  logic [3:0] calc_q,
   input  logic [3:0] calc_sign_q,
   output logic [3:0] opA,
   output logic       signA,
   output logic [3:0] opB,
   output logic       signB,
   output logic [1:0] op_sel,
   output logic [3:0] result,
   output logic [3:0] result_sign,
   output logic [2:0] digit_en,
   output logic       busy,
   output logic       done
);
   typedef enum logic [2:0] {ENTER_A, ENTER_B, ENTER_OP, SETTLE, SHOW} stateT;
   localparam logic [CNT_W-1:0] debLoad = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] settleLoad = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0] blankCode = 4'b1010;
   stateT state;
   logic [1:0] enterSync, clearSync;
   logic enterPrev, clearPrev, enterPress, clearPress, enterAccept, clearAccept;
   logic [CNT_W-1:0] enterHold, clearHold, settleCnt;
   assign enterAccept = enterSync[1] & ~enterPrev & (enterHold == '0);
   assign clearAccept = clearSync[1] & ~clearPrev & (clearHold == '0);
   // synchronise the raw buttons, detect rising edges and run independent hold-off windows
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         enterSync <= '0;
         clearSync <= '0;
         enterPrev <= 1'b0;
         clearPrev <= 1'b0;
         enterPress <= 1'b0;
         clearPress <= 1'b0;
         enterHold <= '0;
         clearHold <= '0;
      end else begin
         enterSync <= {enterSync[0], btn_enter};
         clearSync <= {clearSync[0], btn_clear};
         enterPrev <= enterSync[1];
         clearPrev <= clearSync[1];
         enterPress <= enterAccept;
         clearPress <= clearAccept;
         enterHold <= enterAccept ? debLoad : (enterHold != '0) ? enterHold - 1'b1 : enterHold;
         clearHold <= clearAccept ? debLoad : (clearHold != '0) ? clearHold - 1'b1 : clearHold;
      end
   // entry sequence and result capture; clear overrides any enter in the same cycle
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= ENTER_A;
         settleCnt <= '0;
         opA <= '0;
         signA <= 1'b0;
         opB <= '0;
         signB <= 1'b0;
         op_sel <= '0;
         result <= '0;
         result_sign <= blankCode;
         digit_en <= 3'b001;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (clearPress) begin
         state <= ENTER_A;
         settleCnt <= '0;
         opA <= '0;
         signA <= 1'b0;
         opB <= '0;
         signB <= 1'b0;
         op_sel <= '0;
         result <= '0;
         result_sign <= blankCode;
         digit_en <= 3'b001;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ENTER_A: begin
               opA <= sw_value;
               signA <= sw_sign;
               if (enterPress) begin
                  state <= ENTER_B;
                  digit_en <= 3'b011;
               end
            end
            ENTER_B: begin
               opB <= sw_value;
               signB <= sw_sign;
               if (enterPress) state <= ENTER_OP;
            end
            ENTER_OP: begin
               op_sel <= sw_op;
               if (enterPress) begin
                  state <= SETTLE;
                  settleCnt <= settleLoad;
                  busy <= 1'b1;
               end
            end
            SETTLE: begin
               if (settleCnt == '0) begin
                  result <= calc_q;
                  result_sign <= calc_sign_q;
                  done <= 1'b1;
                  busy <= 1'b0;
                  digit_en <= 3'b111;
                  state <= SHOW;
               end else begin
                  settleCnt <= settleCnt - 1'b1;
               end
            end
            SHOW: begin
               if (enterPress) begin
                  state <= ENTER_A;
                  result <= '0;
                  result_sign <= blankCode;
                  digit_en <= 3'b001;
               end
            end
            default: state <= ENTER_A;
         endcase
      end
endmodule
